// File: rtl/clock_rst_seq_if.sv
// -----------------------------------------------------------------------------
// clock_rst_seq_if
// Signals between the reset sequencer and its surroundings.
//   i_locked     : PLL/MMCM lock, asynchronous to the sequencer clock
//   o_pll_rst    : active-high reset to the PLL primitive
//   o_rst        : per-channel active-high resets; bit 0 is released first
//   o_ready      : all channels released and lock held
//   o_relock_cnt : saturating count of lock losses seen after ready
// The master modport is the sequencer. The slave modport is the
// clock-wrapper/SoC side.
// -----------------------------------------------------------------------------
interface clock_rst_seq_if #(
  parameter int CHANNELS = 2
);
  logic                i_locked;
  logic                o_pll_rst;
  logic [CHANNELS-1:0] o_rst;
  logic                o_ready;
  logic [7:0]          o_relock_cnt;

  modport master (
    input  i_locked,
    output o_pll_rst,
    output o_rst,
    output o_ready,
    output o_relock_cnt
  );

  modport slave (
    output i_locked,
    input  o_pll_rst,
    input  o_rst,
    input  o_ready,
    input  o_relock_cnt
  );
endinterface

// File: rtl/clock_rst_seq.sv
// -----------------------------------------------------------------------------
// clock_rst_seq
// Reset sequencer for the clock-generation path. The block does the following:
//   - pulses the PLL reset;
//   - re-pulses it when lock does not arrive within LOCK_TIMEOUT cycles;
//   - debounces the synchronised lock;
//   - releases CHANNELS domain resets STAGE_DELAY cycles apart;
//   - drops every channel back into reset as soon as lock is lost.
// Ports:
//   i_clk : free-running board clock, all logic on posedge
//   i_rst : synchronous active-high reset
//   bus   : clock_rst_seq_if.master (i_locked in; o_pll_rst, o_rst, o_ready,
//           o_relock_cnt out, all registered)
// -----------------------------------------------------------------------------
module clock_rst_seq #(
  parameter int CHANNELS       = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int STAGE_DELAY    = 8,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int PLL_RST_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  clock_rst_seq_if.master bus
);

  // The counter is sized for the longest interval any state measures, so it
  // never wraps.
  localparam int MAX_AB   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int REL_SPAN = STAGE_DELAY * CHANNELS;
  localparam int MAX_ABC  = (MAX_AB > REL_SPAN) ? MAX_AB : REL_SPAN;
  localparam int MAX_ALL  = (MAX_ABC > PLL_RST_CYCLES) ? MAX_ABC : PLL_RST_CYCLES;
  localparam int CNT_W    = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_AT       = CNT_W'((CHANNELS - 1) * STAGE_DELAY);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                pll_rst_q, pll_rst_d;
  logic [CHANNELS-1:0] rst_q,    rst_d;
  logic                ready_q,  ready_d;
  logic [7:0]          relock_q, relock_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                locked_s;
  logic [CNT_W-1:0]    cnt_inc;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Lock synchroniser. It is cleared by i_rst, so a stale lock can never
  // short-cut the sequence after a reset.
  // NOTE: every register in this block uses non-blocking assignments. This
  // lets each stage sample the value from the previous edge, not the value
  // that was just written.
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_locked};
  end

  // State and output registers. They are plain flops with no memory arrays,
  // so all of them take the synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= '1;
      ready_q   <= 1'b0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
      relock_q  <= relock_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pll_rst_d = pll_rst_q;
    rst_d     = rst_q;
    ready_d   = ready_q;
    relock_d  = relock_q;

    unique case (state_q)
      S_PLL_RST: begin
        pll_rst_d = 1'b1;
        rst_d     = '1;
        ready_d   = 1'b0;
        if (cnt_q == PLL_LAST) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d  = S_RELEASE;
          cnt_d    = '0;
          rst_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RELEASE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // Channel k is released k*STAGE_DELAY edges after channel 0.
          // It also waits until channel k-1 is out of reset, so channels are
          // never released out of order.
          for (int k = 1; k < CHANNELS; k++) begin
            if (cnt_inc == CNT_W'(k * STAGE_DELAY) && !rst_q[k-1]) rst_d[k] = 1'b0;
          end
          // With a single channel, RELEASE lasts exactly one cycle.
          if (CHANNELS == 1 || cnt_inc == RUN_AT) state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end else begin
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_PLL_RST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        rst_d     = '1;
        ready_d   = 1'b0;
      end
    endcase
  end

  assign bus.o_pll_rst    = pll_rst_q;
  assign bus.o_rst        = rst_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_relock_cnt = relock_q;

endmodule

// File: tb/tb_clock_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clock_rst_seq
// Directed bench for clock_rst_seq with default parameters. Edges are counted
// from the last edge at which i_rst was high (edge 0). Outputs are sampled on
// the falling edge after the edge being checked, and inputs are driven at that
// same point, so they are set up before the next rising edge.
// -----------------------------------------------------------------------------
module tb_clock_rst_seq;

  logic clk = 1'b0;
  logic rst;
  int   edge_no;
  int   n_checks;
  int   n_errors;

  clock_rst_seq_if #(.CHANNELS(2)) bus_if ();

  clock_rst_seq #(
    .CHANNELS      (2),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (16),
    .STAGE_DELAY   (8),
    .LOCK_TIMEOUT  (4096),
    .PLL_RST_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_no++;
    end
    @(negedge clk);
  endtask

  task automatic goto_edge(input int target);
    if (target > edge_no) step(target - edge_no);
  endtask

  // i_locked went high before edge t and stays high. Channel 0 is released
  // at t+18, channel 1 at t+26, and o_ready rises at t+27.
  task automatic lock_seq(input int t);
    goto_edge(t + 17); check("rst_before_rel0", 32'(bus_if.o_rst), 32'd3);
    goto_edge(t + 18); check("rst_rel0",        32'(bus_if.o_rst), 32'd2);
    goto_edge(t + 25); check("rst_before_rel1", 32'(bus_if.o_rst), 32'd2);
    goto_edge(t + 26); check("rst_rel1",        32'(bus_if.o_rst), 32'd0);
                       check("ready_at_rel1",   32'(bus_if.o_ready), 32'd0);
    goto_edge(t + 27); check("ready_rise",      32'(bus_if.o_ready), 32'd1);
                       check("pll_rst_in_run",  32'(bus_if.o_pll_rst), 32'd0);
  endtask

  initial begin
    int t;
    int u;
    n_checks = 0;
    n_errors = 0;
    edge_no  = 0;
    rst      = 1'b1;
    bus_if.i_locked = 1'b0;

    // Reset state.
    step(3);
    check("reset_pll_rst", 32'(bus_if.o_pll_rst),    32'd1);
    check("reset_rst",     32'(bus_if.o_rst),        32'd3);
    check("reset_ready",   32'(bus_if.o_ready),      32'd0);
    check("reset_relock",  32'(bus_if.o_relock_cnt), 32'd0);

    // Retry loop with no lock: 4 cycles of PLL reset, then 4096 cycles waiting.
    rst     = 1'b0;
    edge_no = 0;
    goto_edge(3);    check("pll_rst_hi_e3",    32'(bus_if.o_pll_rst), 32'd1);
    goto_edge(4);    check("pll_rst_lo_e4",    32'(bus_if.o_pll_rst), 32'd0);
    goto_edge(4099); check("pll_rst_lo_e4099", 32'(bus_if.o_pll_rst), 32'd0);
                     check("rst_held_wait",    32'(bus_if.o_rst),     32'd3);
                     check("ready_low_wait",   32'(bus_if.o_ready),   32'd0);
    goto_edge(4100); check("pll_rst_retry",    32'(bus_if.o_pll_rst), 32'd1);
    goto_edge(4103); check("pll_rst_retry_e3", 32'(bus_if.o_pll_rst), 32'd1);
    goto_edge(4104); check("pll_rst_retry_end", 32'(bus_if.o_pll_rst), 32'd0);

    // Lock arrives during WAIT_LOCK.
    bus_if.i_locked = 1'b1;
    t = edge_no + 1;
    lock_seq(t);
    check("relock_zero", 32'(bus_if.o_relock_cnt), 32'd0);

    // Loss in RUN. The check at u+1 holds regardless of the exact loss
    // latency, and by u+3 the outputs must have dropped.
    bus_if.i_locked = 1'b0;
    u = edge_no + 1;
    goto_edge(u + 1); check("run_before_loss", 32'(bus_if.o_rst),        32'd0);
    goto_edge(u + 3); check("loss_rst",        32'(bus_if.o_rst),        32'd3);
                      check("loss_ready",      32'(bus_if.o_ready),      32'd0);
                      check("loss_relock",     32'(bus_if.o_relock_cnt), 32'd1);

    // Glitch: 10 cycles of lock is not enough to pass STABLE.
    bus_if.i_locked = 1'b1;
    step(10);
    bus_if.i_locked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("glitch_rst", 32'(bus_if.o_rst), 32'd3);
    end
    bus_if.i_locked = 1'b1;
    t = edge_no + 1;
    lock_seq(t);

    // Loss in RUN again (relock count 2), then loss between channel releases.
    bus_if.i_locked = 1'b0;
    step(5);
    check("relock_two", 32'(bus_if.o_relock_cnt), 32'd2);
    bus_if.i_locked = 1'b1;
    t = edge_no + 1;
    goto_edge(t + 18); check("mid_rel0", 32'(bus_if.o_rst), 32'd2);
    goto_edge(t + 19);
    bus_if.i_locked = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(1);
      check("mid_rst1_held", 32'(bus_if.o_rst[1]), 32'd1);
    end
    check("mid_rst_all", 32'(bus_if.o_rst),        32'd3);
    check("mid_relock",  32'(bus_if.o_relock_cnt), 32'd2);
    check("mid_ready",   32'(bus_if.o_ready),      32'd0);

    // 300 more losses in RUN: the count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      bus_if.i_locked = 1'b1;
      step(30);
      bus_if.i_locked = 1'b0;
      step(4);
      if (i == 9) check("relock_twelve", 32'(bus_if.o_relock_cnt), 32'd12);
    end
    check("relock_sat", 32'(bus_if.o_relock_cnt), 32'd255);

    // Reset pulse while in RUN, with lock held throughout.
    bus_if.i_locked = 1'b1;
    t = edge_no + 1;
    lock_seq(t);
    rst = 1'b1;
    step(1);
    check("rrst_pll_rst", 32'(bus_if.o_pll_rst),    32'd1);
    check("rrst_rst",     32'(bus_if.o_rst),        32'd3);
    check("rrst_ready",   32'(bus_if.o_ready),      32'd0);
    check("rrst_relock",  32'(bus_if.o_relock_cnt), 32'd0);
    rst     = 1'b0;
    edge_no = 0;
    // PLL_RST covers edges 1-4. The synchroniser refills by edge 2, WAIT_LOCK
    // sees lock at edge 5, and STABLE then samples edges 6-21.
    goto_edge(3);  check("rrst_pll_hi",   32'(bus_if.o_pll_rst), 32'd1);
    goto_edge(4);  check("rrst_pll_lo",   32'(bus_if.o_pll_rst), 32'd0);
    goto_edge(20); check("rrst_pre_rel0", 32'(bus_if.o_rst),     32'd3);
    goto_edge(21); check("rrst_rel0",     32'(bus_if.o_rst),     32'd2);
    goto_edge(29); check("rrst_rel1",     32'(bus_if.o_rst),     32'd0);
    goto_edge(30); check("rrst_ready",    32'(bus_if.o_ready),   32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
